// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: packet-level round-robin arbiter sharing one async FIFO write port.
// Define FIFO_ARB_HEADER_EN to prepend a channel header byte {1, 0..., gid} to each packet.
module fifo_wr_arbiter #(
  parameter int NREQ    = 4,
  parameter int DSIZE   = 8,
  parameter int MAX_PKT = 256
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic [NREQ-1:0]       req_valid_i,
  input  logic [NREQ*DSIZE-1:0] req_data_i,
  input  logic [NREQ-1:0]       req_last_i,
  output logic [NREQ-1:0]       req_ready_o,
  output logic                  fifo_wr_en_o,
  output logic [DSIZE-1:0]      fifo_wr_data_o,
  input  logic                  fifo_full_i,
  output logic [NREQ-1:0]       grant_o,
  output logic                  busy_o,
  output logic                  trunc_o,
  input  logic                  trunc_clr_i
);

  localparam int CHW  = $clog2(NREQ);
  localparam int CNTW = $clog2(MAX_PKT + 1);
  localparam logic [CNTW-1:0] MAX_CNT = CNTW'(MAX_PKT);
  localparam logic [CHW-1:0]  LAST_ID = CHW'(NREQ - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
`ifdef FIFO_ARB_HEADER_EN
    S_HDR  = 2'd1,
`endif
    S_DATA = 2'd2,
    S_DROP = 2'd3
  } state_t;

`ifdef FIFO_ARB_HEADER_EN
  localparam state_t GRANT_STATE = S_HDR;
`else
  localparam state_t GRANT_STATE = S_DATA;
`endif

  state_t            state_q, state_d;
  logic [CHW-1:0]    rr_ptr_q, rr_ptr_d;
  logic [CHW-1:0]    gid_q, gid_d;
  logic [CNTW-1:0]   cnt_q, cnt_d;
  logic [NREQ-1:0]   grant_q, grant_d;
  logic              trunc_q, trunc_d;

  logic [CHW-1:0]    pick_id;
  logic [DSIZE-1:0]  sel_data;
  logic              sel_valid;
  logic              sel_last;
  logic [CNTW-1:0]   cnt_inc;
  logic              end_pkt;

  // First valid requester at or above ptr, wrapping past NREQ-1 back to 0.
  function automatic logic [CHW-1:0] rr_pick(input logic [NREQ-1:0] vld,
                                             input logic [CHW-1:0]  ptr);
    logic [CHW-1:0] id;
    logic           found;
    int             k;
    id    = '0;
    found = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      k = int'(ptr) + i;
      if (k >= NREQ) k = k - NREQ;
      if (!found && vld[CHW'(k)]) begin
        found = 1'b1;
        id    = CHW'(k);
      end
    end
    return id;
  endfunction

  assign pick_id   = rr_pick(req_valid_i, rr_ptr_q);
  assign sel_valid = req_valid_i[gid_q];
  assign sel_last  = req_last_i[gid_q];
  assign cnt_inc   = cnt_q + 1'b1;

  always_comb begin
    sel_data = '0;
    for (int n = 0; n < NREQ; n++) begin
      if (gid_q == CHW'(n)) sel_data = req_data_i[n*DSIZE +: DSIZE];
    end
  end

`ifdef FIFO_ARB_HEADER_EN
  logic [DSIZE-1:0] hdr_byte;

  always_comb begin
    hdr_byte             = '0;
    hdr_byte[DSIZE-1]    = 1'b1;
    hdr_byte[CHW-1:0]    = gid_q;
  end
`endif

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d        = state_q;
    rr_ptr_d       = rr_ptr_q;
    gid_d          = gid_q;
    cnt_d          = cnt_q;
    grant_d        = grant_q;
    trunc_d        = trunc_q;
    end_pkt        = 1'b0;
    req_ready_o    = '0;
    fifo_wr_en_o   = 1'b0;
    fifo_wr_data_o = '0;

    // Clear is applied first so a same-cycle truncation below overrides it.
    if (trunc_clr_i) trunc_d = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (|req_valid_i) begin
          gid_d            = pick_id;
          grant_d          = '0;
          grant_d[pick_id] = 1'b1;
          cnt_d            = '0;
          state_d          = GRANT_STATE;
        end
      end
`ifdef FIFO_ARB_HEADER_EN
      S_HDR: begin
        fifo_wr_data_o = hdr_byte;
        fifo_wr_en_o   = ~fifo_full_i;
        if (!fifo_full_i) state_d = S_DATA;
      end
`endif
      S_DATA: begin
        req_ready_o[gid_q] = ~fifo_full_i;
        fifo_wr_data_o     = sel_data;
        fifo_wr_en_o       = sel_valid & ~fifo_full_i;
        if (sel_valid && !fifo_full_i) begin
          cnt_d = cnt_inc;
          if (sel_last) begin
            end_pkt = 1'b1;
          end else if (cnt_inc == MAX_CNT) begin
            trunc_d = 1'b1;
            state_d = S_DROP;
          end
        end
      end
      S_DROP: begin
        req_ready_o[gid_q] = 1'b1;
        if (sel_valid && sel_last) end_pkt = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    if (end_pkt) begin
      state_d  = S_IDLE;
      grant_d  = '0;
      rr_ptr_d = (gid_q == LAST_ID) ? '0 : gid_q + 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q  <= S_IDLE;
      rr_ptr_q <= '0;
      gid_q    <= '0;
      cnt_q    <= '0;
      grant_q  <= '0;
      trunc_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      gid_q    <= gid_d;
      cnt_q    <= cnt_d;
      grant_q  <= grant_d;
      trunc_q  <= trunc_d;
    end
  end

  assign grant_o = grant_q;
  assign busy_o  = (state_q != S_IDLE);
  assign trunc_o = trunc_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: packet table plus hand-written arbitration,
// stall and reset sequences, with a scoreboard of expected FIFO writes and grants.
module tb_fifo_wr_arbiter;

  localparam int NREQ    = 4;
  localparam int DSIZE   = 8;
  localparam int MAX_PKT = 4;
`ifdef FIFO_ARB_HEADER_EN
  localparam int HDR_EN  = 1;
`else
  localparam int HDR_EN  = 0;
`endif

  logic                  clk_i;
  logic                  reset_i;
  logic [NREQ-1:0]       req_valid_i;
  logic [NREQ*DSIZE-1:0] req_data_i;
  logic [NREQ-1:0]       req_last_i;
  logic [NREQ-1:0]       req_ready_o;
  logic                  fifo_wr_en_o;
  logic [DSIZE-1:0]      fifo_wr_data_o;
  logic                  fifo_full_i;
  logic [NREQ-1:0]       grant_o;
  logic                  busy_o;
  logic                  trunc_o;
  logic                  trunc_clr_i;

  fifo_wr_arbiter #(.NREQ(NREQ), .DSIZE(DSIZE), .MAX_PKT(MAX_PKT)) dut (
    .clk_i          (clk_i),
    .reset_i        (reset_i),
    .req_valid_i    (req_valid_i),
    .req_data_i     (req_data_i),
    .req_last_i     (req_last_i),
    .req_ready_o    (req_ready_o),
    .fifo_wr_en_o   (fifo_wr_en_o),
    .fifo_wr_data_o (fifo_wr_data_o),
    .fifo_full_i    (fifo_full_i),
    .grant_o        (grant_o),
    .busy_o         (busy_o),
    .trunc_o        (trunc_o),
    .trunc_clr_i    (trunc_clr_i)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    int         req;
    logic [7:0] data;
    logic       last;
  } stim_t;

  typedef struct {
    int         req;
    int         len;
    logic [7:0] base;
    logic       clr_hold;
    logic       exp_set;
    logic       exp_final;
  } row_t;

  stim_t      stim_q[$];
  logic [7:0] exp_wr[$];
  logic [3:0] exp_grant[$];
  int         grant_cyc_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  int         cyc = 0;
  int         first_wr_cyc, last_wr_cyc, idle_cyc, trunc_cyc, wr_count;
  logic       was_busy;
  logic [3:0] prev_grant, cur_grant, mon_ready;
  logic       mon_wr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] pbyte(input logic [7:0] base, input int k);
    return base + 8'(k * 17);
  endfunction

  task automatic push_pkt(input int req, input int len, input logic [7:0] base);
    for (int k = 0; k < len; k++) stim_q.push_back('{req, pbyte(base, k), (k == len - 1)});
  endtask

  // Expected FIFO stream for one packet: optional header, then at most MAX_PKT payload bytes.
  task automatic push_exp(input int req, input int len, input logic [7:0] base);
    exp_grant.push_back(4'(1 << req));
    if (HDR_EN != 0) exp_wr.push_back(8'h80 | 8'(req));
    for (int k = 0; k < len && k < MAX_PKT; k++) exp_wr.push_back(pbyte(base, k));
  endtask

  task automatic apply_inputs();
    logic found;
    req_valid_i = '0;
    req_last_i  = '0;
    req_data_i  = '0;
    for (int n = 0; n < NREQ; n++) begin
      found = 1'b0;
      for (int i = 0; i < stim_q.size(); i++) begin
        if (!found && stim_q[i].req == n) begin
          found                        = 1'b1;
          req_valid_i[n]               = 1'b1;
          req_last_i[n]                = stim_q[i].last;
          req_data_i[n*DSIZE +: DSIZE] = stim_q[i].data;
        end
      end
    end
  endtask

  task automatic step();
    logic [NREQ-1:0] hs;
    logic [7:0]      e;
    int              idx;
    apply_inputs();
    @(negedge clk_i);
    hs        = req_valid_i & req_ready_o;
    mon_ready = req_ready_o;
    mon_wr    = fifo_wr_en_o;
    check("wr_while_full", 32'(fifo_wr_en_o & fifo_full_i), 0);
    check("busy_vs_grant", 32'(busy_o), 32'(|grant_o));
    check("ready_outside_grant", 32'(req_ready_o & ~grant_o), 0);
    if (fifo_wr_en_o) begin
      check("unexpected_wr", 32'(exp_wr.size() != 0), 1);
      if (exp_wr.size() != 0) begin
        e = exp_wr.pop_front();
        check("wr_data", 32'(fifo_wr_data_o), 32'(e));
      end
      wr_count++;
      if (first_wr_cyc < 0) first_wr_cyc = cyc;
      last_wr_cyc = cyc;
    end
    if (grant_o != 0 && prev_grant == 0) begin
      check("unexpected_grant", 32'(exp_grant.size() != 0), 1);
      if (exp_grant.size() != 0) begin
        cur_grant = exp_grant.pop_front();
        check("grant_order", 32'(grant_o), 32'(cur_grant));
      end
      grant_cyc_q.push_back(cyc);
    end else if (grant_o != 0) begin
      check("grant_hold", 32'(grant_o), 32'(cur_grant));
    end
    prev_grant = grant_o;
    @(posedge clk_i);
    for (int n = 0; n < NREQ; n++) begin
      if (hs[n]) begin
        idx = -1;
        for (int i = 0; i < stim_q.size(); i++)
          if (idx < 0 && stim_q[i].req == n) idx = i;
        if (idx >= 0) stim_q.delete(idx);
      end
    end
    #1;
    cyc++;
    if (!busy_o && was_busy) idle_cyc = cyc;
    was_busy = busy_o;
    if (trunc_o && trunc_cyc < 0) trunc_cyc = cyc;
  endtask

  task automatic run_until_idle(input int budget);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while ((stim_q.size() != 0 || busy_o) && n < budget);
    check("idle_timeout", 32'(stim_q.size() != 0 || busy_o), 0);
    check("scoreboard_empty", 32'(exp_wr.size() + exp_grant.size()), 0);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_grant"}, 32'(grant_o), 0);
    check({tag, "_busy"}, 32'(busy_o), 0);
    check({tag, "_trunc"}, 32'(trunc_o), 0);
    check({tag, "_ready"}, 32'(req_ready_o), 0);
    check({tag, "_wr_en"}, 32'(fifo_wr_en_o), 0);
    check({tag, "_wr_data"}, 32'(fifo_wr_data_o), 0);
  endtask

  row_t rows[6];

  initial begin
    int wr_target;
    int n;

    rows[0] = '{0, 3, 8'h11, 1'b0, 1'b0, 1'b0};  // 0x11 0x22 0x33
    rows[1] = '{1, 6, 8'h41, 1'b0, 1'b1, 1'b1};  // truncated after 4 bytes
    rows[2] = '{3, 4, 8'hA0, 1'b0, 1'b0, 1'b0};  // last coincides with MAX_PKT
    rows[3] = '{2, 1, 8'h5C, 1'b0, 1'b0, 1'b0};  // single-byte packet
    rows[4] = '{1, 5, 8'h90, 1'b1, 1'b1, 1'b0};  // set beats a held clear
    rows[5] = '{2, 5, 8'hE0, 1'b0, 1'b1, 1'b1};

    reset_i      = 1'b1;
    req_valid_i  = '0;
    req_data_i   = '0;
    req_last_i   = '0;
    fifo_full_i  = 1'b0;
    trunc_clr_i  = 1'b0;
    first_wr_cyc = -1;
    last_wr_cyc  = -1;
    idle_cyc     = -1;
    trunc_cyc    = -1;
    wr_count     = 0;
    was_busy     = 1'b0;
    prev_grant   = '0;
    cur_grant    = '0;
    #1;
    check_outputs_zero("reset");
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    reset_i = 1'b0;
    @(posedge clk_i);
    #1;

    // Reqs 0 and 2 together from reset, then 0 and 3 with the pointer at 3.
    grant_cyc_q.delete();
    push_pkt(0, 2, 8'h11);
    push_pkt(2, 2, 8'h51);
    push_exp(0, 2, 8'h11);
    push_exp(2, 2, 8'h51);
    run_until_idle(40);
    check("b2b_grant_count", 32'(grant_cyc_q.size()), 2);
    if (grant_cyc_q.size() >= 2)
      check("b2b_throughput", 32'(grant_cyc_q[1] - grant_cyc_q[0]), 32'(2 + 1 + HDR_EN));
    push_pkt(0, 2, 8'h21);
    push_pkt(3, 2, 8'h61);
    push_exp(3, 2, 8'h61);
    push_exp(0, 2, 8'h21);
    run_until_idle(40);

    for (int r = 0; r < 6; r++) begin
      if (trunc_o) begin
        trunc_clr_i = 1'b1;
        step();
        trunc_clr_i = 1'b0;
        check("trunc_clear", 32'(trunc_o), 0);
      end
      cyc          = 0;
      first_wr_cyc = -1;
      trunc_cyc    = -1;
      idle_cyc     = -1;
      push_exp(rows[r].req, rows[r].len, rows[r].base);
      push_pkt(rows[r].req, rows[r].len, rows[r].base);
      trunc_clr_i = rows[r].clr_hold;
      run_until_idle(40);
      trunc_clr_i = 1'b0;
      check("row_duration", 32'(idle_cyc), 32'(rows[r].len + 1 + HDR_EN));
      check("row_first_write", 32'(first_wr_cyc), 1);
      check("row_trunc_final", 32'(trunc_o), 32'(rows[r].exp_final));
      if (rows[r].exp_set) check("row_trunc_time", 32'(trunc_cyc), 32'(last_wr_cyc + 1));
      else                 check("row_no_trunc", 32'(trunc_cyc), 32'hFFFF_FFFF);
    end
    trunc_clr_i = 1'b1;
    step();
    trunc_clr_i = 1'b0;

    // FIFO full for 5 cycles after the second payload byte.
    push_pkt(0, 3, 8'hC1);
    push_exp(0, 3, 8'hC1);
    wr_target = wr_count + HDR_EN + 2;
    n = 0;
    while (wr_count < wr_target && n < 20) begin
      step();
      n++;
    end
    check("stall_setup", 32'(wr_count), 32'(wr_target));
    fifo_full_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check("stall_ready", 32'(mon_ready), 0);
      check("stall_wr_en", 32'(mon_wr), 0);
    end
    fifo_full_i = 1'b0;
    run_until_idle(20);

    // Leave trunc set and rr_ptr at 2, then reset in the middle of req 2's payload.
    push_pkt(1, 6, 8'h31);
    push_exp(1, 6, 8'h31);
    run_until_idle(40);
    check("pre_reset_trunc", 32'(trunc_o), 1);
    push_pkt(2, 4, 8'h71);
    push_exp(2, 4, 8'h71);
    wr_target = wr_count + HDR_EN + 1;
    n = 0;
    while (wr_count < wr_target && n < 20) begin
      step();
      n++;
    end
    check("pre_reset_grant", 32'(grant_o), 32'h4);
    #1;
    reset_i = 1'b1;
    #1;
    check_outputs_zero("mid_reset");
    stim_q.delete();
    exp_wr.delete();
    exp_grant.delete();
    req_valid_i = '0;
    req_last_i  = '0;
    req_data_i  = '0;
    prev_grant  = '0;
    was_busy    = 1'b0;
    @(negedge clk_i);
    reset_i = 1'b0;
    @(posedge clk_i);
    #1;
    push_pkt(1, 2, 8'h0A);
    push_pkt(3, 2, 8'h3B);
    push_exp(1, 2, 8'h0A);
    push_exp(3, 2, 8'h3B);
    run_until_idle(40);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
